// File: rtl/vadd_stream_ctrl.sv
// Operand sequencer and writeback stage around the vector adder.
// Streams len element pairs from two read ports into vadd, captures each sum in
// a small result FIFO and drains it as valid/ready write transactions, then
// pulses done. Reads are credit-limited so the FIFO can never overflow.
module vadd_stream_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic [ADDR_W-1:0]     a_base,
    input  logic [ADDR_W-1:0]     b_base,
    input  logic [ADDR_W-1:0]     d_base,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr_a,
    output logic [ADDR_W-1:0]     rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH-1:0] add_sum,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d;
    logic [ADDR_W-1:0]   d_base_q, d_base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    written_q, written_d;
    // Set in the cycle after rd_en: the matching sum is on add_sum now.
    logic                inflight_q;

    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [CntW-1:0]       count_q, count_d;

    logic                push, pop, credit_ok;
    logic [CntW:0]       occupancy;

    // Datapath glue: operands go straight to vadd, outputs decode from state.
    always_comb begin
        add_a     = rd_data_a;
        add_b     = rd_data_b;
        busy      = (state_q == StRun) || (state_q == StDrain);
        done      = (state_q == StDone);
        wr_valid  = (count_q != '0);
        wr_data   = fifo_q[rptr_q];
        wr_addr   = d_base_q + ADDR_W'(written_q);
        rd_addr_a = a_base_q + ADDR_W'(issued_q);
        rd_addr_b = b_base_q + ADDR_W'(issued_q);
        push      = inflight_q;
        pop       = wr_valid && wr_ready;
        count_d   = count_q + CntW'(push) - CntW'(pop);
        // Credit uses start-of-cycle occupancy; a same-cycle pop frees nothing.
        occupancy = (CntW+1)'(count_q) + (CntW+1)'(inflight_q);
        credit_ok = occupancy < (CntW+1)'(FIFO_DEPTH);
        rd_en     = (state_q == StRun) && (issued_q < len_q) && credit_ok;
    end

    // Next-state logic for the sequencer FSM and its counters.
    always_comb begin
        state_d   = state_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        d_base_d  = d_base_q;
        len_d     = len_q;
        issued_d  = issued_q + LEN_W'(rd_en);
        written_d = written_q + LEN_W'(pop);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_base_d  = a_base;
                    b_base_d  = b_base;
                    d_base_d  = d_base;
                    len_d     = len;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en && ((issued_q + LEN_W'(1)) == len_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!inflight_q && (count_d == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_base_q   <= '0;
            b_base_q   <= '0;
            d_base_q   <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            d_base_q   <= d_base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            inflight_q <= rd_en;
        end
    end

    // Result FIFO; storage is cleared so wr_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= add_sum;
                wptr_q         <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_vadd_stream_ctrl.sv
// Directed bench for vadd_stream_ctrl: memory model, combinational vadd model and
// a negedge monitor that logs reads, handshakes, busy and done with cycle numbers
// relative to the cycle in which start was driven.
module tb_vadd_stream_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] a_base = '0, b_base = '0, d_base = '0;
    logic          busy, done, rd_en, wr_valid;
    logic          wr_ready = 1'b1;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
    logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
    logic [DW-1:0] add_a, add_b, add_sum, wr_data;

    logic [DW-1:0] vmem [0:65535];

    vadd_stream_ctrl #(
        .DATA_WIDTH(DW), .ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .a_base(a_base), .b_base(b_base), .d_base(d_base),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // vadd model: wrapping add.
    assign add_sum = add_a + add_b;

    // Read ports with one cycle of latency.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= vmem[rd_addr_a];
            rd_data_b <= vmem[rd_addr_b];
        end
    end

    int cyc = 0;
    int c0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] hs_addr[$];
    logic [DW-1:0] hs_data[$];
    int            hs_cyc[$];
    int            done_cyc[$];
    int            rd_cyc[$];
    logic [AW-1:0] rda_log[$];
    logic [AW-1:0] rdb_log[$];
    int            busy_cyc[$];
    int            wv_cnt = 0;
    int            stall_viol = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (wr_valid !== 1'b1 || wr_addr !== prev_addr ||
                               wr_data !== prev_data)) begin
                stall_viol <= stall_viol + 1;
            end
            prev_stall <= wr_valid && !wr_ready;
            prev_addr  <= wr_addr;
            prev_data  <= wr_data;
            if (wr_valid && wr_ready) begin
                hs_addr.push_back(wr_addr);
                hs_data.push_back(wr_data);
                hs_cyc.push_back(cyc - c0);
            end
            if (done) done_cyc.push_back(cyc - c0);
            if (rd_en) begin
                rd_cyc.push_back(cyc - c0);
                rda_log.push_back(rd_addr_a);
                rdb_log.push_back(rd_addr_b);
            end
            if (busy) busy_cyc.push_back(cyc - c0);
            if (wr_valid) wv_cnt <= wv_cnt + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic clear_logs();
        hs_addr.delete();
        hs_data.delete();
        hs_cyc.delete();
        done_cyc.delete();
        rd_cyc.delete();
        rda_log.delete();
        rdb_log.delete();
        busy_cyc.delete();
    endtask

    // Drives a start strobe; the cycle it is driven in becomes cycle 0.
    task automatic send_cmd(input logic [LW-1:0] l, input logic [AW-1:0] a,
                            input logic [AW-1:0] b, input logic [AW-1:0] d);
        @(posedge clk);
        #1;
        start  = 1'b1;
        len    = l;
        a_base = a;
        b_base = b;
        d_base = d;
        c0     = cyc;
    endtask

    // Runs cycles 1..n; wr_ready low in rlo..rhi, start high in slo..shi.
    task automatic run(input int n, input int rlo, input int rhi, input int slo, input int shi);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            start    = (k >= slo && k <= shi);
            wr_ready = !(k >= rlo && k <= rhi);
        end
        start    = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, rd_en, wr_valid} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, rd_en, wr_valid});
        else n_pass++;
        n_total++;
        if ({rd_addr_a, rd_addr_b, wr_addr} !== 48'h0)
            $display("FAIL reset_addr: got %h expected 0", {rd_addr_a, rd_addr_b, wr_addr});
        else n_pass++;
        n_total++;
        if (wr_data !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", wr_data);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [AW-1:0] ea [4] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
        logic [DW-1:0] ed [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
        for (int i = 0; i < 4; i++) begin
            vmem[i]         = DW'(i + 1);
            vmem[16'h100+i] = DW'(10 * (i + 1));
        end
        clear_logs();
        send_cmd(16'd4, 16'h0000, 16'h0100, 16'h0200);
        run(12, 0, -1, 0, -1);
        n_total++;
        if (hs_addr.size() !== 4) $display("FAIL basic_count: got %0d expected 4", hs_addr.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= hs_addr.size())
                $display("FAIL basic_wr%0d: got none expected %h/%0d", i, ea[i], ed[i]);
            else if (hs_addr[i] !== ea[i] || hs_data[i] !== ed[i] || hs_cyc[i] !== 3 + i)
                $display("FAIL basic_wr%0d: got %h/%0d@%0d expected %h/%0d@%0d", i,
                         hs_addr[i], hs_data[i], hs_cyc[i], ea[i], ed[i], 3 + i);
            else n_pass++;
        end
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 7)
            $display("FAIL basic_done: got %0d pulses first@%0d expected 1@7", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
        n_total++;
        if (rd_cyc.size() !== 4 || rd_cyc[0] !== 1 || rd_cyc[3] !== 4)
            $display("FAIL basic_rd: got %0d reads expected 4 in cycles 1..4", rd_cyc.size());
        else n_pass++;
        n_total++;
        if (busy_cyc.size() !== 6 || busy_cyc[0] !== 1 || busy_cyc[5] !== 6)
            $display("FAIL basic_busy: got %0d cycles expected 6 in cycles 1..6", busy_cyc.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        vmem[16'h0010] = 32'hFFFF_FFFF;
        vmem[16'h0020] = 32'h0000_0002;
        clear_logs();
        send_cmd(16'd1, 16'h0010, 16'h0020, 16'h0030);
        run(8, 0, -1, 0, -1);
        n_total++;
        if (hs_data.size() !== 1 || hs_data[0] !== 32'h1 || hs_addr[0] !== 16'h0030 ||
            hs_cyc[0] !== 3)
            $display("FAIL wrap_sum: got %0d writes first %h expected 1 write 00000001@3",
                     hs_data.size(), (hs_data.size() > 0) ? hs_data[0] : 32'hx);
        else n_pass++;
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 4)
            $display("FAIL wrap_done: got %0d pulses first@%0d expected 1@4", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed [8] = '{32'h101, 32'h202, 32'h303, 32'h404,
                                  32'h505, 32'h606, 32'h707, 32'h808};
        int early;
        int sv0;
        for (int i = 0; i < 8; i++) begin
            vmem[16'h0040+i] = DW'(32'h100 * (i + 1));
            vmem[16'h0140+i] = DW'(i + 1);
        end
        clear_logs();
        sv0 = stall_viol;
        send_cmd(16'd8, 16'h0040, 16'h0140, 16'h0400);
        run(30, 3, 10, 0, -1);
        early = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] <= 10) early++;
        n_total++;
        if (early !== FD) $display("FAIL bp_credit: got %0d reads by cycle 10 expected %0d",
                                   early, FD);
        else n_pass++;
        n_total++;
        if (rd_cyc.size() !== 8) $display("FAIL bp_reads: got %0d expected 8", rd_cyc.size());
        else n_pass++;
        n_total++;
        if (stall_viol - sv0 !== 0)
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_viol - sv0);
        else n_pass++;
        n_total++;
        if (hs_addr.size() !== 8) $display("FAIL bp_count: got %0d expected 8", hs_addr.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (i >= hs_addr.size())
                $display("FAIL bp_wr%0d: got none expected %h", i, ed[i]);
            else if (hs_addr[i] !== AW'(16'h0400 + i) || hs_data[i] !== ed[i] ||
                     hs_cyc[i] !== 11 + i)
                $display("FAIL bp_wr%0d: got %h/%h@%0d expected %h/%h@%0d", i, hs_addr[i],
                         hs_data[i], hs_cyc[i], AW'(16'h0400 + i), ed[i], 11 + i);
            else n_pass++;
        end
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 19)
            $display("FAIL bp_done: got %0d pulses first@%0d expected 1@19", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_zero_and_ignore();
        logic [DW-1:0] ed [3] = '{32'd55, 32'd66, 32'd77};
        int wv0;
        clear_logs();
        wv0 = wv_cnt;
        send_cmd(16'd0, 16'h0000, 16'h0000, 16'h0700);
        run(5, 0, -1, 0, -1);
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 1)
            $display("FAIL zero_done: got %0d pulses first@%0d expected 1@1", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
        n_total++;
        if (rd_cyc.size() + busy_cyc.size() + (wv_cnt - wv0) !== 0)
            $display("FAIL zero_quiet: got rd=%0d busy=%0d wv=%0d expected all 0",
                     rd_cyc.size(), busy_cyc.size(), wv_cnt - wv0);
        else n_pass++;

        for (int i = 0; i < 3; i++) begin
            vmem[16'h0060+i] = DW'(5 + i);
            vmem[16'h0160+i] = DW'(50 + 10 * i);
        end
        clear_logs();
        send_cmd(16'd3, 16'h0060, 16'h0160, 16'h0600);
        run(15, 0, -1, 1, 4);
        n_total++;
        if (hs_addr.size() !== 3) $display("FAIL ign_count: got %0d expected 3", hs_addr.size());
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= hs_addr.size())
                $display("FAIL ign_wr%0d: got none expected %0d", i, ed[i]);
            else if (hs_addr[i] !== AW'(16'h0600 + i) || hs_data[i] !== ed[i])
                $display("FAIL ign_wr%0d: got %h/%0d expected %h/%0d", i, hs_addr[i],
                         hs_data[i], AW'(16'h0600 + i), ed[i]);
            else n_pass++;
        end
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 6)
            $display("FAIL ign_done: got %0d pulses first@%0d expected 1@6", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] ea [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic [AW-1:0] eb [3] = '{16'h0500, 16'h0501, 16'h0502};
        logic [AW-1:0] ew [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        logic [DW-1:0] ed [3] = '{32'd101, 32'd202, 32'd303};
        vmem[16'hFFFE] = 32'd1;
        vmem[16'hFFFF] = 32'd2;
        vmem[16'h0000] = 32'd3;
        vmem[16'h0500] = 32'd100;
        vmem[16'h0501] = 32'd200;
        vmem[16'h0502] = 32'd300;
        clear_logs();
        send_cmd(16'd3, 16'hFFFE, 16'h0500, 16'hFFFF);
        run(10, 0, -1, 0, -1);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (i >= rda_log.size())
                $display("FAIL awrap_rd%0d: got none expected %h/%h", i, ea[i], eb[i]);
            else if (rda_log[i] !== ea[i] || rdb_log[i] !== eb[i])
                $display("FAIL awrap_rd%0d: got %h/%h expected %h/%h", i, rda_log[i],
                         rdb_log[i], ea[i], eb[i]);
            else n_pass++;
            n_total++;
            if (i >= hs_addr.size())
                $display("FAIL awrap_wr%0d: got none expected %h/%0d", i, ew[i], ed[i]);
            else if (hs_addr[i] !== ew[i] || hs_data[i] !== ed[i])
                $display("FAIL awrap_wr%0d: got %h/%0d expected %h/%0d", i, hs_addr[i],
                         hs_data[i], ew[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin
            vmem[16'h0800+i] = DW'(i);
            vmem[16'h0900+i] = 32'd1000;
        end
        clear_logs();
        send_cmd(16'd16, 16'h0800, 16'h0900, 16'h0A00);
        run(7, 0, -1, 0, -1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done, rd_en, wr_valid} !== 4'b0000)
            $display("FAIL rstmid_ctrl: got %b expected 0000", {busy, done, rd_en, wr_valid});
        else n_pass++;
        n_total++;
        if ({rd_addr_a, rd_addr_b, wr_addr} !== 48'h0 || wr_data !== 32'h0)
            $display("FAIL rstmid_data: got %h/%h expected 0/0",
                     {rd_addr_a, rd_addr_b, wr_addr}, wr_data);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(30, 0, -1, 0, -1);
        n_total++;
        if (hs_addr.size() !== 5) $display("FAIL rstmid_writes: got %0d expected 5",
                                           hs_addr.size());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (i >= hs_addr.size())
                $display("FAIL rstmid_wr%0d: got none expected %0d", i, 1000 + i);
            else if (hs_addr[i] !== AW'(16'h0A00 + i) || hs_data[i] !== DW'(1000 + i))
                $display("FAIL rstmid_wr%0d: got %h/%0d expected %h/%0d", i, hs_addr[i],
                         hs_data[i], AW'(16'h0A00 + i), 1000 + i);
            else n_pass++;
        end
        n_total++;
        if (done_cyc.size() !== 0) $display("FAIL rstmid_nodone: got %0d expected 0",
                                            done_cyc.size());
        else n_pass++;

        vmem[16'h0810] = 32'd7;
        vmem[16'h0910] = 32'd8;
        vmem[16'h0811] = 32'd9;
        vmem[16'h0911] = 32'd10;
        clear_logs();
        send_cmd(16'd2, 16'h0810, 16'h0910, 16'h0B00);
        run(10, 0, -1, 0, -1);
        n_total++;
        if (hs_data.size() !== 2 || hs_data[0] !== 32'd15 || hs_data[1] !== 32'd19 ||
            hs_addr[0] !== 16'h0B00 || hs_addr[1] !== 16'h0B01 || hs_cyc[1] !== 4)
            $display("FAIL after_rst_writes: got %0d writes expected 15@B00,19@B01",
                     hs_data.size());
        else n_pass++;
        n_total++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== 5)
            $display("FAIL after_rst_done: got %0d pulses first@%0d expected 1@5",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_zero_and_ignore();
        test_addr_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
